// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes and
// datapath mux selects, plus the packed control word the decoder produces.
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,
        S_DECODE = 5'd1,
        S_RX     = 5'd2,
        S_RWB    = 5'd3,
        S_IX     = 5'd4,
        S_IWB    = 5'd5,
        S_MADDR  = 5'd6,
        S_LRD    = 5'd7,
        S_LWB    = 5'd8,
        S_SWR    = 5'd9,
        S_BEQ    = 5'd10,
        S_BNE    = 5'd11,
        S_JMP    = 5'd12,
        S_JAL    = 5'd13,
        S_JR     = 5'd14,
        S_HALT   = 5'd30,
        S_ILL    = 5'd31
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;
    localparam logic [3:0] OP_JAL   = 4'h7;
    localparam logic [3:0] OP_JR    = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2,
        PCSRC_REG    = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        SRCB_REG   = 2'd0,
        SRCB_TWO   = 2'd1,
        SRCB_IMM   = 2'd2,
        SRCB_SHIMM = 2'd3
    } srcb_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_IMM   = 2'd3
    } aluop_t;

    typedef struct packed {
        logic   pc_write;
        logic   pc_write_cond;
        logic   iord;
        logic   mem_read;
        logic   mem_write;
        logic   ir_write;
        logic   reg_write;
        logic   mem_to_reg;
        logic   reg_dst;
        logic   alu_src_a;
        pcsrc_t pc_src;
        srcb_t  alu_src_b;
        aluop_t alu_op;
        logic   halted;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Control-word decoder: maps the current state onto every datapath control.
// Only FETCH (memory ready) and the two branch states (Zero) look at inputs.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t cs,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    // Decode the control word for the current state; unlisted fields stay 0
    always_comb begin
        ctrl = '0;
        case (cs)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = SRCB_TWO;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_SHIMM;
            S_RX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_IX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_IMM;
            end
            S_IWB: ctrl.reg_write = 1'b1;
            S_MADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_LRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_LWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_SWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            // Branch condition is folded in here so the datapath needs no Zero logic
            S_BEQ, S_BNE: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.pc_write_cond = (cs == S_BEQ) ? zero : ~zero;
            end
            S_JMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            S_JAL: ctrl.reg_write = 1'b1;
            S_JR: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_REG;
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences the datapath one instruction at a time,
// stalling in FETCH/LRD/SWR until memory signals ready.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 5,
    parameter int unsigned OP_W    = 4
) (
    input  logic               CLK,
    input  logic               ResetL,
    input  logic [OP_W-1:0]    Opcode,
    input  logic               Zero,
    input  logic               MemReady,
    output logic [STATE_W-1:0] CS,
    output logic [STATE_W-1:0] NS,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               ALUSrcA,
    output logic [1:0]         PCSrc,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               Halted
);

    state_t cs, ns;
    ctrl_t  ctrl;

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!ResetL) cs <= S_FETCH;
        else         cs <= ns;
    end

    // Next-state logic: dispatch in DECODE, memory stalls, HALT absorbs
    always_comb begin
        ns = S_FETCH;
        case (cs)
            S_FETCH:  ns = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_W'(OP_RTYPE):       ns = S_RX;
                    OP_W'(OP_ADDI):        ns = S_IX;
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):          ns = S_MADDR;
                    OP_W'(OP_BEQ):         ns = S_BEQ;
                    OP_W'(OP_BNE):         ns = S_BNE;
                    OP_W'(OP_J):           ns = S_JMP;
                    OP_W'(OP_JAL):         ns = S_JAL;
                    OP_W'(OP_JR):          ns = S_JR;
                    OP_W'(OP_HALT):        ns = S_HALT;
                    default:               ns = S_ILL;
                endcase
            end
            S_RX:     ns = S_RWB;
            S_IX:     ns = S_IWB;
            S_MADDR: begin
                if (Opcode == OP_W'(OP_LW))      ns = S_LRD;
                else if (Opcode == OP_W'(OP_SW)) ns = S_SWR;
                else                             ns = S_FETCH;
            end
            S_LRD:    ns = MemReady ? S_LWB : S_LRD;
            S_SWR:    ns = MemReady ? S_FETCH : S_SWR;
            S_JAL:    ns = S_JMP;
            S_HALT,
            S_ILL:    ns = S_HALT;
            default:  ns = S_FETCH;
        endcase
    end

    ctrl_decode u_decode (
        .cs        (cs),
        .mem_ready (MemReady),
        .zero      (Zero),
        .ctrl      (ctrl)
    );

    assign CS          = STATE_W'(cs);
    assign NS          = STATE_W'(ns);
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign MemToReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign PCSrc       = ctrl.pc_src;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign Halted      = ctrl.halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// state path (with random stalls), then walked cycle by cycle against the DUT.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       ResetL = 1'b0;
    logic [3:0] Opcode = '0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic [4:0] CS, NS;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, MemToReg, RegDst, ALUSrcA, Halted;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int st;
        bit mr;
    } step_t;

    multicycle_ctrl #(.STATE_W(5), .OP_W(4)) dut (
        .CLK(CLK), .ResetL(ResetL), .Opcode(Opcode), .Zero(Zero),
        .MemReady(MemReady), .CS(CS), .NS(NS),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .Halted(Halted)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected control outputs for a state number, straight from the state table
    function automatic logic [16:0] exp_ctrl(input int st, input bit mr, input bit z);
        logic pw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic rw = 0, m2r = 0, rd = 0, sa = 0, hlt = 0;
        logic [1:0] psrc = 0, srcb = 0, aop = 0;
        case (st)
            0:  begin mrd = 1; irw = mr; pw = mr; srcb = 1; end
            1:  srcb = 3;
            2:  begin sa = 1; aop = 2; end
            3:  begin rw = 1; rd = 1; end
            4:  begin sa = 1; srcb = 2; aop = 3; end
            5:  rw = 1;
            6:  begin sa = 1; srcb = 2; end
            7:  begin mrd = 1; iord = 1; end
            8:  begin rw = 1; m2r = 1; end
            9:  begin mwr = 1; iord = 1; end
            10: begin sa = 1; aop = 1; psrc = 1; pwc = z; end
            11: begin sa = 1; aop = 1; psrc = 1; pwc = !z; end
            12: begin pw = 1; psrc = 2; end
            13: rw = 1;
            14: begin pw = 1; psrc = 3; end
            30: hlt = 1;
            default: ;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, rw, m2r, rd, sa, psrc, srcb, aop, hlt};
    endfunction

    function automatic logic [16:0] dut_ctrl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                MemToReg, RegDst, ALUSrcA, PCSrc, ALUSrcB, ALUOp, Halted};
    endfunction

    // Entered at a falling edge; drives MemReady, checks, leaves at the next falling edge
    task automatic tick_check(input int est, input bit mr, input int ens);
        MemReady = mr;
        #1;
        check($sformatf("cs@%0d", est), 32'(CS), 32'(est));
        check($sformatf("ns@%0d", est), 32'(NS), 32'(ens));
        check($sformatf("ctrl@%0d", est), 32'(dut_ctrl()), 32'(exp_ctrl(est, mr, Zero)));
        check("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        ResetL = 1'b0;
        MemReady = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        ResetL = 1'b1;
        #1;
        check("rst_cs", 32'(CS), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd1);
        check("rst_irwrite", 32'(IRWrite), 32'd1);
    endtask

    // Expand one instruction into its expected state path and walk it
    task automatic run_instr(input int op, input bit z, input int fw, input int mw);
        step_t path[$];
        int    term;
        Opcode = 4'(op);
        Zero   = z;
        for (int i = 0; i < fw; i++) path.push_back('{0, 1'b0});
        path.push_back('{0, 1'b1});
        path.push_back('{1, 1'($urandom)});
        term = 0;
        case (op)
            0: begin path.push_back('{2, 1'($urandom)}); path.push_back('{3, 1'($urandom)}); end
            1: begin path.push_back('{4, 1'($urandom)}); path.push_back('{5, 1'($urandom)}); end
            2: begin
                path.push_back('{6, 1'($urandom)});
                for (int i = 0; i < mw; i++) path.push_back('{7, 1'b0});
                path.push_back('{7, 1'b1});
                path.push_back('{8, 1'($urandom)});
            end
            3: begin
                path.push_back('{6, 1'($urandom)});
                for (int i = 0; i < mw; i++) path.push_back('{9, 1'b0});
                path.push_back('{9, 1'b1});
            end
            4: path.push_back('{10, 1'($urandom)});
            5: path.push_back('{11, 1'($urandom)});
            6: path.push_back('{12, 1'($urandom)});
            7: begin path.push_back('{13, 1'($urandom)}); path.push_back('{12, 1'($urandom)}); end
            8: path.push_back('{14, 1'($urandom)});
            15: begin
                for (int i = 0; i < 10; i++) path.push_back('{30, 1'($urandom)});
                term = 30;
            end
            default: begin
                path.push_back('{31, 1'($urandom)});
                for (int i = 0; i < 3; i++) path.push_back('{30, 1'($urandom)});
                term = 30;
            end
        endcase
        for (int i = 0; i < path.size(); i++)
            tick_check(path[i].st, path[i].mr, (i + 1 < path.size()) ? path[i + 1].st : term);
    endtask

    initial begin
        int op;
        @(negedge CLK);
        do_reset();

        // Directed sequences
        run_instr(0, 1'b0, 0, 0);
        run_instr(2, 1'b0, 0, 3);
        run_instr(4, 1'b1, 0, 0);
        run_instr(4, 1'b0, 1, 0);
        run_instr(5, 1'b1, 0, 0);
        run_instr(5, 1'b0, 0, 0);
        run_instr(7, 1'b0, 0, 0);
        run_instr(3, 1'b0, 2, 2);
        run_instr(15, 1'b0, 0, 0);
        do_reset();
        run_instr(9, 1'b0, 0, 0);
        do_reset();

        // Reset while a store is stalled on memory
        Opcode = 4'd3;
        tick_check(0, 1'b1, 1);
        tick_check(1, 1'b0, 6);
        tick_check(6, 1'b0, 9);
        tick_check(9, 1'b0, 9);
        tick_check(9, 1'b0, 9);
        ResetL = 1'b0;
        MemReady = 1'b0;
        @(negedge CLK);
        ResetL = 1'b1;
        #1;
        check("abort_cs", 32'(CS), 32'd0);
        check("abort_memwrite", 32'(MemWrite), 32'd0);
        @(negedge CLK);

        // Random instruction stream
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 15);
            run_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
            if (op >= 9) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
